// File: rtl/vend_pkg.sv
// Shared types for the change dispenser: change codes, coin unit weights, FSM states, queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vend_pkg;

  // Change is counted in nickel units: code 0..4 = 0/5/10/15/20 cents.
  typedef logic [2:0] chg_code_t;

  localparam chg_code_t MAX_CODE    = 3'd4;
  localparam chg_code_t UNIT_DIME   = 3'd2;
  localparam chg_code_t UNIT_NICKEL = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SODA,
    ST_COIN_SEL,
    ST_COIN_WAIT,
    ST_FAULT
  } disp_state_t;

  // One queued vend/refund event.
  typedef struct packed {
    logic      soda;
    chg_code_t units;
  } req_t;

  function automatic logic code_valid(input chg_code_t c);
    return (c <= MAX_CODE);
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Request queue: DEPTH x W entries, first-word-fall-through read, push/pop/full/empty.
// Latency: a pushed word is visible at o_pop_dat the cycle after the push edge.
// Backpressure: none upstream; a push while full is accepted only if a pop happens on the same edge.
// Ports: i_clk, i_rst_n, i_push/i_push_dat (write), i_pop/o_pop_dat (read), o_full, o_empty.
module vend_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_pop_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign o_full    = (cnt_q == FULL_CNT);
  assign o_empty   = (cnt_q == '0);
  assign do_pop    = i_pop & ~o_empty;
  // A full queue can still take a word when a slot frees on the same edge.
  assign do_push   = i_push & (~o_full | do_pop);
  assign o_pop_dat = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Queues vend/refund events and drives soda release and coin eject one item at a time, greedy dimes first.
// Latency: event at edge k into an idle, empty dispenser -> first mechanism output high after edge k+2.
// Backpressure: none upstream; events arriving on a full queue are dropped and flagged via o_overflow.
// Ports: i_clk, i_rst_n; i_soda/i_change event in; i_mech_done ack; i_refill inventory reload;
//        o_soda_rel/o_dime_ej/o_nickel_ej mechanism drives; o_busy; sticky o_overflow/o_bad_code/o_fault;
//        o_dimes/o_nickels inventory.
module change_dispenser #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIME_INIT   = 8,
  parameter int NICKEL_INIT = 16,
  parameter int CNT_W       = 6,
  parameter int TIMEOUT     = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_soda,
  input  logic [2:0]       i_change,
  input  logic             i_mech_done,
  input  logic             i_refill,
  output logic             o_soda_rel,
  output logic             o_dime_ej,
  output logic             o_nickel_ej,
  output logic             o_busy,
  output logic             o_overflow,
  output logic             o_bad_code,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_dimes,
  output logic [CNT_W-1:0] o_nickels
);
  import vend_pkg::*;

  // The wait timer only ever reaches TIMEOUT-1.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  req_t                push_req, head_req;
  logic [$bits(req_t)-1:0] head_dat;
  logic                fifo_full, fifo_empty;
  logic                evt, code_ok, push, pop, ack, timeout_hit;

  disp_state_t         state_q, state_d;
  chg_code_t           rem_q, rem_d;
  logic                coin_dime_q, coin_dime_d;
  logic [CNT_W-1:0]    dimes_q, dimes_d, nickels_q, nickels_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                soda_rel_q, soda_rel_d, dime_ej_q, dime_ej_d, nickel_ej_q, nickel_ej_d;
  logic                overflow_q, overflow_d, bad_code_q, bad_code_d, fault_q, fault_d;

  assign evt            = i_soda | (i_change != '0);
  assign code_ok        = code_valid(i_change);
  assign push           = evt & code_ok;
  assign push_req.soda  = i_soda;
  assign push_req.units = i_change;
  assign head_req       = req_t'(head_dat);

  vend_req_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(req_t))) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (push),
    .i_push_dat (push_req),
    .i_pop      (pop),
    .o_pop_dat  (head_dat),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty)
  );

  // An ack only counts while a mechanism is actually being driven.
  assign ack         = i_mech_done & (soda_rel_q | dime_ej_q | nickel_ej_q);
  assign timeout_hit = (tmr_q == TMR_LAST);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    coin_dime_d = coin_dime_q;
    dimes_d     = dimes_q;
    nickels_d   = nickels_q;
    pop         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rem_d   = head_req.units;
          state_d = head_req.soda ? ST_SODA : ST_COIN_SEL;
        end
      end
      ST_SODA: begin
        if (ack)              state_d = ST_COIN_SEL;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_COIN_SEL: begin
        if (rem_q == '0) begin
          state_d = ST_IDLE;
        end else if (rem_q >= UNIT_DIME && dimes_q != '0) begin
          coin_dime_d = 1'b1;
          state_d     = ST_COIN_WAIT;
        end else if (nickels_q != '0) begin
          coin_dime_d = 1'b0;
          state_d     = ST_COIN_WAIT;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_COIN_WAIT: begin
        if (ack) begin
          if (coin_dime_q) begin
            dimes_d = dimes_q - CNT_W'(1);
            rem_d   = rem_q - UNIT_DIME;
          end else begin
            nickels_d = nickels_q - CNT_W'(1);
            rem_d     = rem_q - UNIT_NICKEL;
          end
          state_d = ST_COIN_SEL;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      default: state_d = ST_FAULT;
    endcase

    // Refill overrides any decrement on the same edge.
    if (i_refill) begin
      dimes_d   = CNT_W'(DIME_INIT);
      nickels_d = CNT_W'(NICKEL_INIT);
    end

    // Soda release rises one cycle into SODA so its timing matches the coin path
    // (COIN_SEL then COIN_WAIT); coin ejects rise on entry to COIN_WAIT.
    soda_rel_d  = (state_q == ST_SODA) && (state_d == ST_SODA);
    dime_ej_d   = (state_d == ST_COIN_WAIT) && coin_dime_d;
    nickel_ej_d = (state_d == ST_COIN_WAIT) && !coin_dime_d;

    tmr_d = ((state_q == ST_SODA || state_q == ST_COIN_WAIT) && state_d == state_q)
            ? tmr_q + TW'(1) : '0;

    overflow_d = overflow_q | (push & fifo_full & ~pop);
    bad_code_d = bad_code_q | (evt & ~code_ok);
    fault_d    = fault_q | (state_d == ST_FAULT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      coin_dime_q <= 1'b0;
      dimes_q     <= CNT_W'(DIME_INIT);
      nickels_q   <= CNT_W'(NICKEL_INIT);
      tmr_q       <= '0;
      soda_rel_q  <= 1'b0;
      dime_ej_q   <= 1'b0;
      nickel_ej_q <= 1'b0;
      overflow_q  <= 1'b0;
      bad_code_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      coin_dime_q <= coin_dime_d;
      dimes_q     <= dimes_d;
      nickels_q   <= nickels_d;
      tmr_q       <= tmr_d;
      soda_rel_q  <= soda_rel_d;
      dime_ej_q   <= dime_ej_d;
      nickel_ej_q <= nickel_ej_d;
      overflow_q  <= overflow_d;
      bad_code_q  <= bad_code_d;
      fault_q     <= fault_d;
    end
  end

  assign o_soda_rel  = soda_rel_q;
  assign o_dime_ej   = dime_ej_q;
  assign o_nickel_ej = nickel_ej_q;
  assign o_busy      = (state_q != ST_IDLE) | ~fifo_empty;
  assign o_overflow  = overflow_q;
  assign o_bad_code  = bad_code_q;
  assign o_fault     = fault_q;
  assign o_dimes     = dimes_q;
  assign o_nickels   = nickels_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: scoreboard of expected mechanism items, background mechanism responder.
// Latency: n/a.
// Backpressure: responder acks after a programmable hold, or withholds acks entirely.
module tb_change_dispenser;
  localparam int FIFO_DEPTH  = 4;
  localparam int DIME_INIT   = 8;
  localparam int NICKEL_INIT = 16;
  localparam int CNT_W       = 6;
  localparam int TIMEOUT     = 255;
  localparam int K_SODA = 0, K_DIME = 1, K_NICKEL = 2;

  logic clk = 1'b0;
  logic rst_n, i_soda, mech_done, refill;
  logic [2:0] i_change;
  logic o_soda_rel, o_dime_ej, o_nickel_ej, o_busy, o_overflow, o_bad_code, o_fault;
  logic [CNT_W-1:0] o_dimes, o_nickels;

  int checks = 0;
  int errors = 0;
  int served = 0;
  int exp_q[$];
  bit ack_en = 1'b1;
  int ack_dly = 1;
  int hold = 0;
  int kind, exp_kind;

  always #5 clk = ~clk;

  change_dispenser #(
    .FIFO_DEPTH(FIFO_DEPTH), .DIME_INIT(DIME_INIT), .NICKEL_INIT(NICKEL_INIT),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_soda(i_soda), .i_change(i_change),
    .i_mech_done(mech_done), .i_refill(refill),
    .o_soda_rel(o_soda_rel), .o_dime_ej(o_dime_ej), .o_nickel_ej(o_nickel_ej),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_bad_code(o_bad_code), .o_fault(o_fault),
    .o_dimes(o_dimes), .o_nickels(o_nickels)
  );

  // Mechanism model: once an output has been high for ack_dly sampled cycles, check it
  // against the scoreboard head and pulse i_mech_done for one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !ack_en || !(o_soda_rel | o_dime_ej | o_nickel_ej)) begin
        hold = 0;
      end else begin
        hold++;
        if (hold >= ack_dly) begin
          checks++;
          if ((int'(o_soda_rel) + int'(o_dime_ej) + int'(o_nickel_ej)) != 1) begin
            errors++;
            $display("FAIL onehot rel/dime/nickel got %b%b%b want exactly one high",
                     o_soda_rel, o_dime_ej, o_nickel_ej);
          end
          kind = o_soda_rel ? K_SODA : (o_dime_ej ? K_DIME : K_NICKEL);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL item_order got kind %0d want no item (scoreboard empty)", kind);
          end else begin
            exp_kind = exp_q.pop_front();
            if (kind !== exp_kind) begin
              errors++;
              $display("FAIL item_order got kind %0d want %0d", kind, exp_kind);
            end
          end
          served++;
          mech_done = 1'b1;
          @(negedge clk);
          mech_done = 1'b0;
          hold = 0;
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; i_soda = 1'b0; i_change = '0; mech_done = 1'b0; refill = 1'b0;
    exp_q.delete();
    served = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Holds one event on the inputs for n consecutive clock edges.
  task automatic burst(input int n, input logic soda, input logic [2:0] chg);
    @(negedge clk);
    i_soda = soda; i_change = chg;
    repeat (n) @(negedge clk);
    i_soda = 1'b0; i_change = '0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!o_busy && exp_q.size() == 0 && !(o_soda_rel | o_dime_ej | o_nickel_ej)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({o_soda_rel, o_dime_ej, o_nickel_ej, o_busy, o_overflow, o_bad_code, o_fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {o_soda_rel, o_dime_ej, o_nickel_ej, o_busy, o_overflow, o_bad_code, o_fault});
    end
    checks++;
    if (o_dimes !== CNT_W'(DIME_INIT)) begin
      errors++; $display("FAIL reset_dimes got %0d want %0d", o_dimes, DIME_INIT);
    end
    checks++;
    if (o_nickels !== CNT_W'(NICKEL_INIT)) begin
      errors++; $display("FAIL reset_nickels got %0d want %0d", o_nickels, NICKEL_INIT);
    end
  endtask

  task automatic test_soda_dime();
    bit ok;
    apply_reset();
    ack_en = 1'b1; ack_dly = 3;
    exp_q.push_back(K_SODA); exp_q.push_back(K_DIME);
    burst(1, 1'b1, 3'd2);
    @(posedge clk); #1;
    checks++;
    if (o_soda_rel !== 1'b0) begin
      errors++; $display("FAIL latency_early soda_rel got %b want 0", o_soda_rel);
    end
    @(posedge clk); #1;
    checks++;
    if (o_soda_rel !== 1'b1) begin
      errors++; $display("FAIL latency soda_rel got %b want 1", o_soda_rel);
    end
    wait_idle(100, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL soda_dime_done got busy=%b pending=%0d want idle", o_busy, exp_q.size());
    end
    checks++;
    if (o_dimes !== CNT_W'(7) || o_nickels !== CNT_W'(16)) begin
      errors++; $display("FAIL soda_dime_inv got %0d/%0d want 7/16", o_dimes, o_nickels);
    end
  endtask

  task automatic test_dime_then_nickels();
    bit ok;
    apply_reset();
    ack_en = 1'b1; ack_dly = 1;
    repeat (6) exp_q.push_back(K_DIME);
    exp_q.push_back(K_DIME);
    burst(3, 1'b0, 3'd4);
    burst(1, 1'b0, 3'd2);
    wait_idle(200, ok);
    checks++;
    if (ok !== 1'b1 || o_dimes !== CNT_W'(1) || o_overflow !== 1'b0) begin
      errors++; $display("FAIL drain_to_one got ok=%b dimes=%0d ovf=%b want 1/1/0", ok, o_dimes, o_overflow);
    end
    exp_q.push_back(K_DIME); exp_q.push_back(K_NICKEL); exp_q.push_back(K_NICKEL);
    burst(1, 1'b0, 3'd4);
    wait_idle(100, ok);
    checks++;
    if (ok !== 1'b1 || o_dimes !== CNT_W'(0) || o_nickels !== CNT_W'(14)) begin
      errors++; $display("FAIL dime_nickel_fallback got ok=%b inv=%0d/%0d want 1 0/14", ok, o_dimes, o_nickels);
    end
  endtask

  task automatic test_back_to_back_overflow();
    bit ok;
    apply_reset();
    ack_en = 1'b0; ack_dly = 1;
    repeat (FIFO_DEPTH + 1) exp_q.push_back(K_NICKEL);
    burst(FIFO_DEPTH + 2, 1'b0, 3'd1);
    @(negedge clk);
    checks++;
    if (o_overflow !== 1'b1 || o_bad_code !== 1'b0) begin
      errors++; $display("FAIL overflow_flag got ovf=%b bad=%b want 1/0", o_overflow, o_bad_code);
    end
    ack_en = 1'b1;
    wait_idle(200, ok);
    checks++;
    if (ok !== 1'b1 || served !== FIFO_DEPTH + 1) begin
      errors++; $display("FAIL overflow_served got ok=%b served=%0d want 1/%0d", ok, served, FIFO_DEPTH + 1);
    end
    checks++;
    if (o_nickels !== CNT_W'(NICKEL_INIT - FIFO_DEPTH - 1)) begin
      errors++; $display("FAIL overflow_nickels got %0d want %0d", o_nickels, NICKEL_INIT - FIFO_DEPTH - 1);
    end
  endtask

  task automatic test_insufficient();
    bit ok, seen;
    apply_reset();
    ack_en = 1'b1; ack_dly = 1;
    repeat (8) exp_q.push_back(K_DIME);
    burst(4, 1'b0, 3'd4);
    wait_idle(300, ok);
    repeat (14) exp_q.push_back(K_NICKEL);
    burst(4, 1'b0, 3'd3);
    wait_idle(300, ok);
    burst(1, 1'b0, 3'd2);
    wait_idle(100, ok);
    checks++;
    if (ok !== 1'b1 || o_dimes !== CNT_W'(0) || o_nickels !== CNT_W'(2)) begin
      errors++; $display("FAIL setup_low_inv got ok=%b inv=%0d/%0d want 1 0/2", ok, o_dimes, o_nickels);
    end
    exp_q.push_back(K_NICKEL); exp_q.push_back(K_NICKEL);
    burst(1, 1'b0, 3'd3);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (o_fault) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || exp_q.size() != 0 || o_nickels !== CNT_W'(0)) begin
      errors++; $display("FAIL coin_fault got fault=%b pending=%0d nickels=%0d want 1/0/0", seen, exp_q.size(), o_nickels);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({o_soda_rel, o_dime_ej, o_nickel_ej, o_busy} !== 4'b0001) begin
      errors++; $display("FAIL fault_outputs got %b want 0001", {o_soda_rel, o_dime_ej, o_nickel_ej, o_busy});
    end
  endtask

  task automatic test_timeout_and_async_reset();
    bit seen;
    apply_reset();
    ack_en = 1'b0;
    burst(1, 1'b0, 3'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (o_nickel_ej) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL eject_start got %b want 1", seen);
    end
    repeat (TIMEOUT + 10) @(negedge clk);
    checks++;
    if (o_fault !== 1'b1 || o_nickel_ej !== 1'b0 || o_nickels !== CNT_W'(NICKEL_INIT)) begin
      errors++; $display("FAIL timeout got fault=%b ej=%b nickels=%0d want 1/0/%0d", o_fault, o_nickel_ej, o_nickels, NICKEL_INIT);
    end
    refill = 1'b1; @(negedge clk); refill = 1'b0; @(negedge clk);
    checks++;
    if (o_fault !== 1'b1) begin
      errors++; $display("FAIL refill_keeps_fault got %b want 1", o_fault);
    end

    apply_reset();
    ack_en = 1'b0;
    burst(1, 1'b0, 3'd2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (o_dime_ej) seen = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seen !== 1'b1 || {o_soda_rel, o_dime_ej, o_nickel_ej, o_busy, o_fault} !== 5'b0) begin
      errors++; $display("FAIL async_reset got seen=%b outs=%b want 1 00000", seen,
                         {o_soda_rel, o_dime_ej, o_nickel_ej, o_busy, o_fault});
    end
    checks++;
    if (o_dimes !== CNT_W'(DIME_INIT)) begin
      errors++; $display("FAIL async_reset_dimes got %0d want %0d", o_dimes, DIME_INIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bad_code_refill();
    bit ok, seen;
    apply_reset();
    ack_en = 1'b1; ack_dly = 2;
    exp_q.push_back(K_NICKEL);
    burst(1, 1'b0, 3'd1);
    wait_idle(50, ok);
    checks++;
    if (ok !== 1'b1 || o_nickels !== CNT_W'(15)) begin
      errors++; $display("FAIL one_nickel got ok=%b nickels=%0d want 1/15", ok, o_nickels);
    end
    burst(1, 1'b0, 3'd6);
    repeat (3) @(negedge clk);
    checks++;
    if ({o_bad_code, o_busy, o_soda_rel, o_dime_ej, o_nickel_ej, o_overflow} !== 6'b100000) begin
      errors++; $display("FAIL bad_code got %b want 100000",
                         {o_bad_code, o_busy, o_soda_rel, o_dime_ej, o_nickel_ej, o_overflow});
    end
    ack_en = 1'b0;
    burst(1, 1'b0, 3'd2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (o_dime_ej) seen = 1'b1;
    end
    mech_done = 1'b1; refill = 1'b1;
    @(negedge clk);
    mech_done = 1'b0; refill = 1'b0;
    @(negedge clk);
    checks++;
    if (seen !== 1'b1 || o_dimes !== CNT_W'(DIME_INIT) || o_nickels !== CNT_W'(NICKEL_INIT)) begin
      errors++; $display("FAIL refill_wins got seen=%b inv=%0d/%0d want 1 %0d/%0d", seen, o_dimes, o_nickels,
                         DIME_INIT, NICKEL_INIT);
    end
    checks++;
    if (o_dime_ej !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL refill_ack_release got ej=%b busy=%b want 0/0", o_dime_ej, o_busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_soda = 1'b0; i_change = '0; mech_done = 1'b0; refill = 1'b0;
    test_reset();
    test_soda_dime();
    test_dime_then_nickels();
    test_back_to_back_overflow();
    test_insufficient();
    test_timeout_and_async_reset();
    test_bad_code_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog got no finish want finish before 300000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
